axi_master_bridge: RTL and testbench
====================================

// Module: axi_master_bridge
// PURPOSE
//  AXI4 initiator for the npc core. Converts one core-side request (load/store/line refill)
//  into an AXI read (AR+R) or write (AW+W+B) transaction toward the SDRAM responder.
//  At most one transaction is outstanding.
//  Read beats are streamed back to the core as they arrive; a write returns one completion.
// PARAMETERS
//  ADDR_W   32  AXI/core address width
//  DATA_W   64  AXI/core data width; arsize/awsize fixed to log2(DATA_W/8)=3
// PORTS
//  clk          in   1       single clock, all logic on posedge
//  rst_n        in   1       asynchronous, active-low reset
//  req_valid    in   1       core request valid
//  req_ready    out  1       bridge idle, request accepted when req_valid&req_ready
//  req_we       in   1       1=write, 0=read
//  req_addr     in   ADDR_W  start address, DATA_W-aligned
//  req_len      in   8       beats-1 (AXI len encoding)
//  wd_valid     in   1       core write beat valid
//  wd_ready     out  1       write beat accepted
//  wd_data      in   DATA_W  write beat data
//  wd_strb      in   DATA_W/8 write byte strobes
//  rsp_valid    out  1       read beat / write completion valid
//  rsp_ready    in   1       core accepts response
//  rsp_rdata    out  DATA_W  read beat data (0 for write completion)
//  rsp_last     out  1       last read beat, or write completion
//  rsp_err      out  1       rresp/bresp != 2'b00
//  araddr,arlen,arsize,arburst,arvalid out / arready in   AXI AR channel
//  rdata,rresp,rlast,rvalid in / rready out                AXI R channel
//  awaddr,awlen,awsize,awburst,awvalid out / awready in   AXI AW channel
//  wdata,wstrb,wlast,wvalid out / wready in               AXI W channel
//  bresp,bvalid in / bready out                           AXI B channel
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, beat counter=0. arvalid, awvalid, wvalid, rready,
//   bready, rsp_valid, wd_ready=0; req_ready=1 once rst_n=1. Mid-transaction reset aborts;
//   no recovery of AXI state.
//  FSM: IDLE, AR, R, AW, W, B.
//  IDLE: req_ready=1. On accept, register addr/len; next state is AW if req_we, else AR.
//  AR: arvalid=1 with registered araddr/arlen, arsize=3, arburst=2'b01 (INCR).
//   Outputs are stable until arready; arvalid&arready -> R.
//  R: rready=rsp_ready; rsp_valid=rvalid; rsp_rdata=rdata; rsp_last=rlast;
//   rsp_err=|rresp (combinational pass-through, zero latency).
//   On rvalid&rready&rlast -> IDLE; rlast is trusted over the local count.
//  AW: awvalid=1 with awsize=3, awburst=INCR. awvalid&awready -> W, wcnt=0.
//  W: wvalid=wd_valid; wd_ready=wready; wdata/wstrb pass-through; wlast=(wcnt==len).
//   Each wvalid&wready increments wcnt. A beat with wlast -> B. No W beat before the
//   AW handshake.
//  B: bready=rsp_ready; rsp_valid=bvalid; rsp_last=1; rsp_rdata=0; rsp_err=|bresp.
//   bvalid&bready -> IDLE.
//  Latency: request accept -> arvalid/awvalid is 1 cycle. Back-to-back requests: the next
//   req_ready is 1 cycle after the final R/B handshake.
//  Valid outputs never deassert before their handshake. Counters are 8 bits; len=255
//   gives 256 beats with no wrap.
//  Error responses do not abort a read burst; all beats are still forwarded.
// TESTING
//  1. Read addr=0x80000000 len=0, arready delayed 3 cycles -> arvalid held 4 cycles with
//     stable outputs; one rsp with rsp_last=1 and data equal to memory.
//  2. Read len=3, rsp_ready toggling 1010 -> 4 beats in order, addresses +8 each on the
//     responder; rready mirrors rsp_ready; rsp_last only on beat 4.
//  3. Write addr=0x80001000 len=1, data 0x11..,0x22.., strb 0xFF/0x0F -> wlast on beat 2
//     only; one completion with rsp_last=1 and rsp_err=0.
//  4. Write with wd_valid asserted before the awready handshake -> wvalid stays 0 until
//     after the AW handshake; no beat lost.
//  5. bresp=2'b10 -> rsp_err=1; read with rresp=2'b11 on beat 2 of 4 -> err only on
//     that beat, burst completes.
//  6. rst_n=0 during the R state of a len=7 read -> all valids drop the same cycle;
//     after release req_ready=1 and a new read completes normally.

Source files
------------

// File: rtl/axi_master_bridge_if.sv
// ---------------------------------------------------------------------------
// axi_master_bridge_if
//   AXI4 bus between the npc core bridge (initiator) and the SDRAM responder.
//   Carries the five AXI channels used by axi_master_bridge:
//     AR : araddr, arlen, arsize, arburst, arvalid / arready
//     R  : rdata, rresp, rlast, rvalid / rready
//     AW : awaddr, awlen, awsize, awburst, awvalid / awready
//     W  : wdata, wstrb, wlast, wvalid / wready
//     B  : bresp, bvalid / bready
//   Modports:
//     master : the bridge side (drives addresses, write data, R/B ready)
//     slave  : the responder side (drives ready, read data, write response)
// ---------------------------------------------------------------------------
interface axi_master_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);

  // read address channel
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  // read data channel
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  // write address channel
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  // write data channel
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  // write response channel
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_master_bridge.sv
// ---------------------------------------------------------------------------
// axi_master_bridge
//   AXI4 initiator for the npc core. One core request (load, store or line
//   refill) becomes a single AXI read (AR+R) or write (AW+W+B) burst toward
//   the SDRAM responder. Only one transaction is ever outstanding.
//   Read beats stream straight back to the core; a write returns a single
//   completion once the write response arrives.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        core request handshake
//   req_we, req_addr, req_len  direction, DATA_W-aligned start address, beats-1
//   wd_valid/wd_ready          core write-beat handshake
//   wd_data, wd_strb           write beat payload and byte strobes
//   rsp_valid/rsp_ready        response handshake (read beat or write completion)
//   rsp_rdata, rsp_last, rsp_err  response payload
//   axi                        AXI4 master modport (AR, R, AW, W, B channels)
// ---------------------------------------------------------------------------
module axi_master_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [7:0]          req_len,

  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic [DATA_W/8-1:0] wd_strb,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_last,
  output logic                rsp_err,

  axi_master_bridge_if.master axi
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_W    = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;

  // Every beat is a full bus word, so the size field is log2 of the bus bytes.
  localparam logic [2:0] BEAT_SIZE  = 3'($clog2(DATA_W / 8));
  localparam logic [1:0] BURST_INCR = 2'b01;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        wcnt;

  logic req_fire;
  logic ar_fire;
  logic r_fire;
  logic aw_fire;
  logic w_fire;
  logic b_fire;
  logic w_is_last;

  // req_ready is gated by rst_n so the core never sees the bridge as idle
  // while it is still held in reset.
  assign req_ready = (state == S_IDLE) && rst_n;
  assign req_fire  = req_valid && req_ready;

  assign ar_fire   = (state == S_AR) && axi.arready;
  assign r_fire    = (state == S_R)  && axi.rvalid && rsp_ready;
  assign aw_fire   = (state == S_AW) && axi.awready;
  assign w_fire    = (state == S_W)  && wd_valid && axi.wready;
  assign b_fire    = (state == S_B)  && axi.bvalid && rsp_ready;

  // The local beat count only decides wlast on the write side; on reads the
  // responder's rlast is authoritative.
  assign w_is_last = (wcnt == len_q);

  // State register plus the captured request. addr/len stay frozen for the
  // whole burst so the AR/AW payload is stable until its handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr_q <= '0;
      len_q  <= '0;
      wcnt   <= '0;
    end else begin
      state <= state_next;
      if (req_fire) begin
        addr_q <= req_addr;
        len_q  <= req_len;
      end
      if (aw_fire) begin
        wcnt <= '0;
      end else if (w_fire) begin
        wcnt <= wcnt + 8'd1;
      end
    end
  end

  // Next-state decode: each phase advances only on its own channel handshake.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req_fire) begin
          state_next = req_we ? S_AW : S_AR;
        end
      end
      S_AR: begin
        if (ar_fire) begin
          state_next = S_R;
        end
      end
      S_R: begin
        if (r_fire && axi.rlast) begin
          state_next = S_IDLE;
        end
      end
      S_AW: begin
        if (aw_fire) begin
          state_next = S_W;
        end
      end
      S_W: begin
        if (w_fire && w_is_last) begin
          state_next = S_B;
        end
      end
      S_B: begin
        if (b_fire) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Address channels: driven purely from state and the captured request, so
  // valid and payload cannot move until the responder accepts them.
  assign axi.arvalid = (state == S_AR);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = BEAT_SIZE;
  assign axi.arburst = BURST_INCR;

  assign axi.awvalid = (state == S_AW);
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = BEAT_SIZE;
  assign axi.awburst = BURST_INCR;

  // Write data is a zero-latency pass-through, opened only in the W phase so
  // nothing leaks onto the bus before the AW handshake.
  assign axi.wvalid = (state == S_W) && wd_valid;
  assign axi.wdata  = wd_data;
  assign axi.wstrb  = wd_strb;
  assign axi.wlast  = w_is_last;
  assign wd_ready   = (state == S_W) && axi.wready;

  // The core's response ready is steered to whichever channel is returning.
  assign axi.rready = (state == S_R) && rsp_ready;
  assign axi.bready = (state == S_B) && rsp_ready;

  // Response mux: read beats pass through untouched; a write completion is a
  // single last-flagged beat with zero data. Error responses never abort a
  // burst, they are only flagged on the beat that carried them.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
    if (state == S_R) begin
      rsp_valid = axi.rvalid;
      rsp_rdata = axi.rdata;
      rsp_last  = axi.rlast;
      rsp_err   = |axi.rresp;
    end else if (state == S_B) begin
      rsp_valid = axi.bvalid;
      rsp_last  = 1'b1;
      rsp_err   = |axi.bresp;
    end
  end

  // Address valids must hold, with an unchanged payload, until accepted.
  ar_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (axi.arvalid && !axi.arready) |=> (axi.arvalid && $stable(axi.araddr) && $stable(axi.arlen)));

  aw_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (axi.awvalid && !axi.awready) |=> (axi.awvalid && $stable(axi.awaddr) && $stable(axi.awlen)));

endmodule

// File: tb/tb_axi_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_master_bridge
//   Bench for axi_master_bridge. A behavioural SDRAM responder answers the
//   AXI side with random handshake delays; a word-addressed reference memory
//   predicts every core-side response, which is queued when the request is
//   issued and popped by an independent monitor when the bridge responds.
//   Inputs change 1 time unit after the rising edge; everything is sampled
//   on the falling edge, so a valid&ready seen there completes on the next
//   rising edge.
// ---------------------------------------------------------------------------
module tb_axi_master_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic              wd_valid;
  logic              wd_ready;
  logic [DATA_W-1:0] wd_data;
  logic [7:0]        wd_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;
  logic              rsp_err;

  axi_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axi_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wd_valid  (wd_valid),
    .wd_ready  (wd_ready),
    .wd_data   (wd_data),
    .wd_strb   (wd_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err),
    .axi       (axi)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;

  rsp_t exp_rsp[$];
  cmd_t exp_ar[$];
  cmd_t exp_aw[$];

  int total = 0;
  int bad   = 0;

  // per-transaction plans chosen by the stimulus
  logic [63:0] wbeat_data [256];
  logic [7:0]  wbeat_strb [256];
  logic [1:0]  rresp_plan [256];
  logic [1:0]  bresp_plan;
  int          ar_delay = 1;
  int          aw_delay = 1;
  bit          rsp_toggle = 1'b0;

  // reference memory (predicted) and responder memory (what really got written)
  logic [63:0] ref_mem  [logic [31:0]];
  logic [63:0] resp_mem [logic [31:0]];

  function automatic logic [63:0] init_word(input logic [31:0] a);
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  function automatic logic [63:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [63:0] resp_read(input logic [31:0] a);
    if (resp_mem.exists(a)) return resp_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                        input logic [7:0] strb);
    logic [63:0] r;
    r = old_w;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: bound expired at %0t", name, $time);
  endtask

  // -------------------------------------------------------------------------
  // Scoreboard monitor: every accepted response must match the queue head.
  // -------------------------------------------------------------------------
  initial begin : scoreboard
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          failNow("unexpected_rsp");
        end else begin
          e = exp_rsp.pop_front();
          checkOutput("rsp_rdata", rsp_rdata, e.data);
          checkOutput("rsp_last", 64'(rsp_last), 64'(e.last));
          checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
    end
  end

  // Core-side response ready: either random back-pressure or a strict 1010 toggle.
  initial begin : rsp_ready_gen
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rsp_toggle) rsp_ready = ~rsp_ready;
      else            rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // -------------------------------------------------------------------------
  // Behavioural SDRAM responder with protocol checks on the bridge's outputs.
  // -------------------------------------------------------------------------
  initial begin : responder
    bit          r_active, w_active, b_pend, expect_idle;
    int          r_beat, w_beat, b_wait, ar_seen, aw_seen;
    logic [31:0] r_addr, w_addr;
    logic [7:0]  r_len, w_len;
    bit          s_arvalid, s_awvalid, s_ar_hs, s_aw_hs, s_r_hs, s_rlast, s_w_hs, s_wlast, s_b_hs;
    logic [31:0] s_araddr, s_awaddr;
    logic [7:0]  s_arlen, s_awlen, s_wstrb;
    logic [63:0] s_wdata;

    r_active = 0; w_active = 0; b_pend = 0; expect_idle = 0;
    r_beat = 0; w_beat = 0; b_wait = 0; ar_seen = 0; aw_seen = 0;
    r_addr = '0; w_addr = '0; r_len = '0; w_len = '0;
    s_araddr = '0; s_awaddr = '0; s_arlen = '0; s_awlen = '0; s_wstrb = '0; s_wdata = '0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 0; axi.rlast = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;

    forever begin
      @(negedge clk);
      s_arvalid = 0; s_awvalid = 0; s_ar_hs = 0; s_aw_hs = 0;
      s_r_hs = 0; s_rlast = 0; s_w_hs = 0; s_wlast = 0; s_b_hs = 0;
      if (rst_n) begin
        if (expect_idle) begin
          checkOutput("req_ready_after_done", 64'(req_ready), 64'd1);
          expect_idle = 0;
        end
        if (axi.arvalid) begin
          s_arvalid = 1;
          ar_seen++;
          if (exp_ar.size() == 0) begin
            failNow("ar_unexpected");
          end else begin
            checkOutput("araddr", 64'(axi.araddr), 64'(exp_ar[0].addr));
            checkOutput("arlen", 64'(axi.arlen), 64'(exp_ar[0].len));
            checkOutput("arsize", 64'(axi.arsize), 64'd3);
            checkOutput("arburst", 64'(axi.arburst), 64'd1);
          end
          if (axi.arready) begin
            s_ar_hs = 1;
            s_araddr = axi.araddr;
            s_arlen = axi.arlen;
            checkOutput("ar_hold_cycles", 64'(ar_seen), 64'(ar_delay + 1));
          end
        end
        if (axi.awvalid) begin
          s_awvalid = 1;
          aw_seen++;
          if (exp_aw.size() == 0) begin
            failNow("aw_unexpected");
          end else begin
            checkOutput("awaddr", 64'(axi.awaddr), 64'(exp_aw[0].addr));
            checkOutput("awlen", 64'(axi.awlen), 64'(exp_aw[0].len));
            checkOutput("awsize", 64'(axi.awsize), 64'd3);
            checkOutput("awburst", 64'(axi.awburst), 64'd1);
          end
          if (axi.awready) begin
            s_aw_hs = 1;
            s_awaddr = axi.awaddr;
            s_awlen = axi.awlen;
            checkOutput("aw_hold_cycles", 64'(aw_seen), 64'(aw_delay + 1));
          end
        end
        checkOutput("rready", 64'(axi.rready), 64'(r_active && rsp_ready));
        checkOutput("bready", 64'(axi.bready), 64'(b_pend && rsp_ready));
        if (axi.rvalid && axi.rready) begin
          s_r_hs = 1;
          s_rlast = axi.rlast;
          if (axi.rlast) expect_idle = 1;
        end
        if (axi.wvalid) begin
          checkOutput("w_before_aw", 64'(w_active), 64'd1);
          if (w_active) begin
            checkOutput("wlast", 64'(axi.wlast), 64'(w_beat == int'(w_len)));
            if (axi.wready) begin
              s_w_hs = 1;
              s_wdata = axi.wdata;
              s_wstrb = axi.wstrb;
              s_wlast = axi.wlast;
            end
          end
        end
        if (axi.bvalid && axi.bready) begin
          s_b_hs = 1;
          expect_idle = 1;
        end
      end

      @(posedge clk); #1;
      if (!rst_n) begin
        r_active = 0; w_active = 0; b_pend = 0; expect_idle = 0;
        ar_seen = 0; aw_seen = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
      end else begin
        // read address / read data
        if (s_ar_hs) begin
          axi.arready = 0;
          ar_seen = 0;
          if (exp_ar.size() != 0) void'(exp_ar.pop_front());
          r_active = 1; r_beat = 0; r_addr = s_araddr; r_len = s_arlen;
        end else if (s_arvalid) begin
          axi.arready = (ar_seen >= ar_delay);
        end
        if (s_r_hs) begin
          axi.rvalid = 0;
          if (s_rlast) r_active = 0;
          else         r_beat++;
        end
        if (r_active && !axi.rvalid && ($urandom_range(0, 3) != 0)) begin
          axi.rvalid = 1;
          axi.rdata  = resp_read(r_addr + 32'(r_beat * 8));
          axi.rlast  = (r_beat == int'(r_len));
          axi.rresp  = rresp_plan[r_beat];
        end
        // write address / write data / write response
        if (s_aw_hs) begin
          axi.awready = 0;
          aw_seen = 0;
          if (exp_aw.size() != 0) void'(exp_aw.pop_front());
          w_active = 1; w_beat = 0; w_addr = s_awaddr; w_len = s_awlen;
        end else if (s_awvalid) begin
          axi.awready = (aw_seen >= aw_delay);
        end
        if (s_w_hs) begin
          resp_mem[w_addr + 32'(w_beat * 8)] =
            merge(resp_read(w_addr + 32'(w_beat * 8)), s_wdata, s_wstrb);
          if (s_wlast) begin
            w_active = 0;
            b_pend = 1;
            b_wait = $urandom_range(0, 2);
          end else begin
            w_beat++;
          end
        end
        axi.wready = w_active && ($urandom_range(0, 3) != 0);
        if (s_b_hs) begin
          axi.bvalid = 0;
          b_pend = 0;
        end else if (b_pend && !axi.bvalid) begin
          if (b_wait == 0) begin
            axi.bvalid = 1;
            axi.bresp = bresp_plan;
          end else begin
            b_wait--;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // One core request: predict its responses, hand it over, feed write beats,
  // and optionally wait for the scoreboard to drain.
  // -------------------------------------------------------------------------
  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [7:0] len,
                               input int delay, input bit wait_done);
    cmd_t  c;
    rsp_t  e;
    int    guard;
    int    beat;
    string lat_name;
    c.addr = addr;
    c.len  = len;
    if (we) begin
      aw_delay = delay;
      exp_aw.push_back(c);
      for (int i = 0; i <= int'(len); i++) begin
        ref_mem[addr + 32'(i * 8)] = merge(ref_read(addr + 32'(i * 8)), wbeat_data[i], wbeat_strb[i]);
      end
      e.data = '0; e.last = 1'b1; e.err = (bresp_plan != 2'b00);
      exp_rsp.push_back(e);
    end else begin
      ar_delay = delay;
      exp_ar.push_back(c);
      for (int i = 0; i <= int'(len); i++) begin
        e.data = ref_read(addr + 32'(i * 8));
        e.last = (i == int'(len));
        e.err  = (rresp_plan[i] != 2'b00);
        exp_rsp.push_back(e);
      end
    end

    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_addr = addr; req_len = len;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      failNow("req_accept");
      @(posedge clk); #1;
      req_valid = 0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 0;
    if (we) begin
      wd_valid = 1; wd_data = wbeat_data[0]; wd_strb = wbeat_strb[0];
    end
    @(negedge clk);
    lat_name = we ? "aw_latency" : "ar_latency";
    checkOutput(lat_name, 64'(we ? axi.awvalid : axi.arvalid), 64'd1);
    checkOutput("wrong_addr_valid", 64'(we ? axi.arvalid : axi.awvalid), 64'd0);

    if (we) begin
      beat = 0;
      guard = 0;
      while (beat <= int'(len) && guard < 2000) begin
        if (wd_ready) begin
          @(posedge clk); #1;
          beat++;
          if (beat <= int'(len)) begin
            wd_data = wbeat_data[beat];
            wd_strb = wbeat_strb[beat];
          end else begin
            wd_valid = 0;
          end
        end else begin
          @(posedge clk); #1;
        end
        if (beat <= int'(len)) @(negedge clk);
        guard++;
      end
      if (beat <= int'(len)) begin
        failNow("wd_accept");
        wd_valid = 0;
      end
    end

    if (wait_done) begin
      guard = 0;
      while (exp_rsp.size() != 0 && guard < 1500) begin
        @(negedge clk);
        guard++;
      end
      if (exp_rsp.size() != 0) begin
        failNow("rsp_drain");
        exp_rsp.delete();
      end
    end
  endtask

  task automatic fill_random(input bit allow_err);
    for (int i = 0; i < 256; i++) begin
      wbeat_data[i] = {$urandom, $urandom};
      wbeat_strb[i] = 8'($urandom_range(0, 255));
      rresp_plan[i] = (allow_err && $urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    end
    bresp_plan = (allow_err && $urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
  endtask

  // Hard stop in case something wedges outside every bounded wait.
  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int guard;
    logic [31:0] addr;
    req_valid = 0; req_we = 0; req_addr = '0; req_len = '0;
    wd_valid = 0; wd_data = '0; wd_strb = '0;
    fill_random(0);
    rst_n = 0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_arvalid", 64'(axi.arvalid), 64'd0);
    checkOutput("rst_awvalid", 64'(axi.awvalid), 64'd0);
    checkOutput("rst_wvalid", 64'(axi.wvalid), 64'd0);
    checkOutput("rst_rready", 64'(axi.rready), 64'd0);
    checkOutput("rst_bready", 64'(axi.bready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_wd_ready", 64'(wd_ready), 64'd0);
    @(posedge clk); #2;
    rst_n = 1;
    @(negedge clk);
    checkOutput("req_ready_after_reset", 64'(req_ready), 64'd1);

    $display("[TB] single-beat read with slow arready");
    fill_random(0);
    applyStimulus(0, 32'h8000_0000, 8'd0, 3, 1);

    $display("[TB] 4-beat read with toggling rsp_ready");
    rsp_toggle = 1;
    applyStimulus(0, 32'h8000_0100, 8'd3, 1, 1);
    rsp_toggle = 0;

    $display("[TB] 2-beat write with partial strobes, then read back");
    fill_random(0);
    wbeat_data[0] = 64'h1111_1111_1111_1111; wbeat_strb[0] = 8'hFF;
    wbeat_data[1] = 64'h2222_2222_2222_2222; wbeat_strb[1] = 8'h0F;
    applyStimulus(1, 32'h8000_1000, 8'd1, 1, 1);
    applyStimulus(0, 32'h8000_1000, 8'd1, 2, 1);

    $display("[TB] write data offered before the AW handshake");
    fill_random(0);
    applyStimulus(1, 32'h8000_2000, 8'd2, 3, 1);
    applyStimulus(0, 32'h8000_2000, 8'd2, 1, 1);

    $display("[TB] error responses");
    fill_random(0);
    bresp_plan = 2'b10;
    applyStimulus(1, 32'h8000_3000, 8'd0, 1, 1);
    fill_random(0);
    rresp_plan[1] = 2'b11;
    applyStimulus(0, 32'h8000_3000, 8'd3, 2, 1);

    $display("[TB] reset in the middle of a read burst");
    fill_random(0);
    applyStimulus(0, 32'h8000_4000, 8'd7, 1, 0);
    guard = 0;
    while (exp_rsp.size() > 5 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (exp_rsp.size() > 5) failNow("mid_burst_progress");
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    checkOutput("abort_arvalid", 64'(axi.arvalid), 64'd0);
    checkOutput("abort_awvalid", 64'(axi.awvalid), 64'd0);
    checkOutput("abort_wvalid", 64'(axi.wvalid), 64'd0);
    checkOutput("abort_rready", 64'(axi.rready), 64'd0);
    checkOutput("abort_bready", 64'(axi.bready), 64'd0);
    checkOutput("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("abort_wd_ready", 64'(wd_ready), 64'd0);
    exp_rsp.delete();
    exp_ar.delete();
    exp_aw.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1;
    @(negedge clk);
    checkOutput("req_ready_after_abort", 64'(req_ready), 64'd1);
    applyStimulus(0, 32'h8000_4000, 8'd7, 2, 1);

    $display("[TB] random traffic");
    for (int n = 0; n < 24; n++) begin
      fill_random(1);
      addr = 32'h8000_0000 + 32'($urandom_range(0, 63) * 8);
      applyStimulus(bit'($urandom_range(0, 1)), addr, 8'($urandom_range(0, 7)),
                    $urandom_range(1, 3), 1);
    end

    $display("[TB] maximum-length bursts");
    fill_random(0);
    applyStimulus(1, 32'h8001_0000, 8'd255, 1, 1);
    applyStimulus(0, 32'h8001_0000, 8'd255, 2, 1);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
